// File: rtl/mem_arb_pkg.sv
// Purpose: shared encodings, FSM state types and the line-compare helper for mem_req_arbiter.
// Latency: n/a (types and functions only).
// Backpressure: n/a.
// Contents: SZ_* request size encodings, read/write FSM state enums, same_line().
package mem_arb_pkg;

  // Request size encodings, shared by the read and write paths
  localparam logic [2:0] SZ_BYTE = 3'b000;
  localparam logic [2:0] SZ_HALF = 3'b001;
  localparam logic [2:0] SZ_WORD = 3'b010;
  localparam logic [2:0] SZ_LINE = 3'b100;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_REQ  = 2'd1,
    R_RESP = 2'd2
  } rd_state_e;

  typedef enum logic {
    W_IDLE = 1'b0,
    W_REQ  = 1'b1
  } wr_state_e;

  // True when two addresses fall in the same cache line (offset bits ignored)
  function automatic logic same_line(input logic [31:0] a,
                                     input logic [31:0] b,
                                     input int unsigned off_w);
    return (a >> off_w) == (b >> off_w);
  endfunction

endpackage

// File: rtl/arb_pick.sv
// Purpose: combinational one-hot winner selection among NCH requesters.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller gates the grant with its own state.
// Ports: req[NCH] requests, ptr (ARB_RR_EN only) search start, gnt one-hot winner,
//        gnt_vld high when any request is present.
// Config: ARB_RR_EN defined -> round-robin from ptr; undefined -> lowest index wins.
module arb_pick #(
  parameter int NCH   = 4,
  parameter int PTR_W = $clog2(NCH)
) (
  input  logic [NCH-1:0]   req,
`ifdef ARB_RR_EN
  input  logic [PTR_W-1:0] ptr,
`endif
  output logic [NCH-1:0]   gnt,
  output logic             gnt_vld
);

`ifdef ARB_RR_EN
  // Walk the requesters starting at ptr, wrapping at NCH; first hit wins
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      int idx;
      idx = int'(ptr) + k;
      if (idx >= NCH) idx = idx - NCH;
      if (!gnt_vld && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_vld  = 1'b1;
      end
    end
  end
`else
  // Fixed priority: lowest requesting index wins
  always_comb begin
    gnt     = '0;
    gnt_vld = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      if (!gnt_vld && req[i]) begin
        gnt[i]  = 1'b1;
        gnt_vld = 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/mem_req_arbiter.sv
// Purpose: arbitrates NCH cache/uncache agents onto one cache-to-AXI bridge, with independent read/write paths.
// Latency: ch_*_rdy combinational in the request cycle; bridge rd_req/wr_req one cycle later.
// Backpressure: one read and one write in flight; channels wait for rdy, bridge stalls via rd_rdy/wr_rdy.
// Ports: ch_rd_* / ch_wr_* per-channel request buses (flattened, channel i at slice i),
//        ch_ret_* routed response beats, rd_* / wr_* / ret_* bridge side.
// Config: ARB_RR_EN selects round-robin arbitration per path (default fixed priority).
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NCH    = 4,
  parameter int LINE_W = 128,
  parameter int OFF_W  = $clog2(LINE_W/8)
) (
  input  logic                  clk,
  input  logic                  resetn,
  // channel read side
  input  logic [NCH-1:0]        ch_rd_req,
  input  logic [3*NCH-1:0]      ch_rd_type,
  input  logic [32*NCH-1:0]     ch_rd_addr,
  output logic [NCH-1:0]        ch_rd_rdy,
  output logic [NCH-1:0]        ch_ret_valid,
  output logic [NCH-1:0]        ch_ret_last,
  output logic [31:0]           ch_ret_data,
  // channel write side
  input  logic [NCH-1:0]        ch_wr_req,
  input  logic [3*NCH-1:0]      ch_wr_type,
  input  logic [32*NCH-1:0]     ch_wr_addr,
  input  logic [4*NCH-1:0]      ch_wr_wstrb,
  input  logic [LINE_W*NCH-1:0] ch_wr_data,
  output logic [NCH-1:0]        ch_wr_rdy,
  // bridge read side
  output logic                  rd_req,
  output logic [2:0]            rd_type,
  output logic [31:0]           rd_addr,
  input  logic                  rd_rdy,
  input  logic                  ret_valid,
  input  logic                  ret_last,
  input  logic [31:0]           ret_data,
  // bridge write side
  output logic                  wr_req,
  output logic [2:0]            wr_type,
  output logic [31:0]           wr_addr,
  output logic [3:0]            wr_wstrb,
  output logic [LINE_W-1:0]     wr_data,
  input  logic                  wr_rdy
);

  localparam int PTR_W = $clog2(NCH);

  rd_state_e          rd_state_q, rd_state_d;
  wr_state_e          wr_state_q, wr_state_d;
  logic [PTR_W-1:0]   rd_gnt_q;

  logic [NCH-1:0]     rd_elig;
  logic [NCH-1:0]     rd_pick, wr_pick;
  logic               rd_pick_vld, wr_pick_vld;
  logic               rd_take, wr_take;

  logic [PTR_W-1:0]   rd_pick_idx;
  logic [2:0]         rd_sel_type;
  logic [31:0]        rd_sel_addr;
  logic [2:0]         wr_sel_type;
  logic [31:0]        wr_sel_addr;
  logic [3:0]         wr_sel_wstrb;
  logic [LINE_W-1:0]  wr_sel_data;

`ifdef ARB_RR_EN
  logic [PTR_W-1:0]   rd_ptr_q, wr_ptr_q;
  logic [PTR_W-1:0]   wr_pick_idx;

  function automatic logic [PTR_W-1:0] ptr_after(input logic [PTR_W-1:0] g);
    if (int'(g) == NCH - 1) return '0;
    return g + 1'b1;
  endfunction
`endif

  // Return data is broadcast; only the valid/last strobes are steered
  assign ch_ret_data = ret_data;

  // A read to the line currently held by the write FSM must wait until the
  // write has been handed to the bridge, otherwise it could return stale data.
  // Blocked channels simply drop out of arbitration so others can still win.
  always_comb begin
    rd_elig = '0;
    for (int i = 0; i < NCH; i++) begin
      rd_elig[i] = ch_rd_req[i] &&
                   !((wr_state_q == W_REQ) &&
                     same_line(ch_rd_addr[i*32 +: 32], wr_addr, OFF_W));
    end
  end

  arb_pick #(.NCH(NCH), .PTR_W(PTR_W)) u_rd_pick (
    .req     (rd_elig),
`ifdef ARB_RR_EN
    .ptr     (rd_ptr_q),
`endif
    .gnt     (rd_pick),
    .gnt_vld (rd_pick_vld)
  );

  arb_pick #(.NCH(NCH), .PTR_W(PTR_W)) u_wr_pick (
    .req     (ch_wr_req),
`ifdef ARB_RR_EN
    .ptr     (wr_ptr_q),
`endif
    .gnt     (wr_pick),
    .gnt_vld (wr_pick_vld)
  );

  // Mux the winning channel's fields using the one-hot grant
  always_comb begin
    rd_pick_idx = '0;
    rd_sel_type = '0;
    rd_sel_addr = '0;
    for (int i = 0; i < NCH; i++) begin
      if (rd_pick[i]) begin
        rd_pick_idx = PTR_W'(i);
        rd_sel_type = ch_rd_type[i*3 +: 3];
        rd_sel_addr = ch_rd_addr[i*32 +: 32];
      end
    end
  end

  always_comb begin
    wr_sel_type  = '0;
    wr_sel_addr  = '0;
    wr_sel_wstrb = '0;
    wr_sel_data  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_pick[i]) begin
        wr_sel_type  = ch_wr_type[i*3 +: 3];
        wr_sel_addr  = ch_wr_addr[i*32 +: 32];
        wr_sel_wstrb = ch_wr_wstrb[i*4 +: 4];
        wr_sel_data  = ch_wr_data[i*LINE_W +: LINE_W];
      end
    end
  end

  assign rd_take = (rd_state_q == R_IDLE) && rd_pick_vld;
  assign wr_take = (wr_state_q == W_IDLE) && wr_pick_vld;

  // Read FSM: next state and outputs
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_req       = 1'b0;
    ch_rd_rdy    = '0;
    ch_ret_valid = '0;
    ch_ret_last  = '0;
    case (rd_state_q)
      R_IDLE: begin
        ch_rd_rdy = rd_pick;
        if (rd_pick_vld) rd_state_d = R_REQ;
      end
      R_REQ: begin
        rd_req = 1'b1;
        if (rd_rdy) rd_state_d = R_RESP;
      end
      R_RESP: begin
        ch_ret_valid[rd_gnt_q] = ret_valid;
        ch_ret_last[rd_gnt_q]  = ret_last;
        if (ret_valid && ret_last) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Write FSM: next state and outputs
  always_comb begin
    wr_state_d = wr_state_q;
    wr_req     = 1'b0;
    ch_wr_rdy  = '0;
    case (wr_state_q)
      W_IDLE: begin
        ch_wr_rdy = wr_pick;
        if (wr_pick_vld) wr_state_d = W_REQ;
      end
      W_REQ: begin
        wr_req = 1'b1;
        if (wr_rdy) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Read state and captured request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_state_q <= R_IDLE;
      rd_gnt_q   <= '0;
      rd_type    <= '0;
      rd_addr    <= '0;
    end else begin
      rd_state_q <= rd_state_d;
      if (rd_take) begin
        rd_gnt_q <= rd_pick_idx;
        rd_type  <= rd_sel_type;
        rd_addr  <= rd_sel_addr;
      end
    end
  end

  // Write state and captured request
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_state_q <= W_IDLE;
      wr_type    <= '0;
      wr_addr    <= '0;
      wr_wstrb   <= '0;
      wr_data    <= '0;
    end else begin
      wr_state_q <= wr_state_d;
      if (wr_take) begin
        wr_type  <= wr_sel_type;
        wr_addr  <= wr_sel_addr;
        wr_wstrb <= wr_sel_wstrb;
        wr_data  <= wr_sel_data;
      end
    end
  end

`ifdef ARB_RR_EN
  always_comb begin
    wr_pick_idx = '0;
    for (int i = 0; i < NCH; i++) begin
      if (wr_pick[i]) wr_pick_idx = PTR_W'(i);
    end
  end

  // The channel after the last winner gets first look next time
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      if (rd_take) rd_ptr_q <= ptr_after(rd_pick_idx);
      if (wr_take) wr_ptr_q <= ptr_after(wr_pick_idx);
    end
  end
`endif

endmodule

// File: tb/tb_mem_req_arbiter.sv
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

  localparam int NCH    = 4;
  localparam int LINE_W = 128;

  logic                  clk = 1'b0;
  logic                  resetn;
  logic [NCH-1:0]        ch_rd_req;
  logic [3*NCH-1:0]      ch_rd_type;
  logic [32*NCH-1:0]     ch_rd_addr;
  logic [NCH-1:0]        ch_rd_rdy;
  logic [NCH-1:0]        ch_ret_valid;
  logic [NCH-1:0]        ch_ret_last;
  logic [31:0]           ch_ret_data;
  logic [NCH-1:0]        ch_wr_req;
  logic [3*NCH-1:0]      ch_wr_type;
  logic [32*NCH-1:0]     ch_wr_addr;
  logic [4*NCH-1:0]      ch_wr_wstrb;
  logic [LINE_W*NCH-1:0] ch_wr_data;
  logic [NCH-1:0]        ch_wr_rdy;
  logic                  rd_req;
  logic [2:0]            rd_type;
  logic [31:0]           rd_addr;
  logic                  rd_rdy;
  logic                  ret_valid;
  logic                  ret_last;
  logic [31:0]           ret_data;
  logic                  wr_req;
  logic [2:0]            wr_type;
  logic [31:0]           wr_addr;
  logic [3:0]            wr_wstrb;
  logic [LINE_W-1:0]     wr_data;
  logic                  wr_rdy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_req_arbiter #(.NCH(NCH), .LINE_W(LINE_W)) dut (
    .clk(clk), .resetn(resetn),
    .ch_rd_req(ch_rd_req), .ch_rd_type(ch_rd_type), .ch_rd_addr(ch_rd_addr),
    .ch_rd_rdy(ch_rd_rdy), .ch_ret_valid(ch_ret_valid), .ch_ret_last(ch_ret_last),
    .ch_ret_data(ch_ret_data),
    .ch_wr_req(ch_wr_req), .ch_wr_type(ch_wr_type), .ch_wr_addr(ch_wr_addr),
    .ch_wr_wstrb(ch_wr_wstrb), .ch_wr_data(ch_wr_data), .ch_wr_rdy(ch_wr_rdy),
    .rd_req(rd_req), .rd_type(rd_type), .rd_addr(rd_addr), .rd_rdy(rd_rdy),
    .ret_valid(ret_valid), .ret_last(ret_last), .ret_data(ret_data),
    .wr_req(wr_req), .wr_type(wr_type), .wr_addr(wr_addr), .wr_wstrb(wr_wstrb),
    .wr_data(wr_data), .wr_rdy(wr_rdy)
  );

  task automatic clear_inputs();
    ch_rd_req = '0; ch_rd_type = '0; ch_rd_addr = '0;
    ch_wr_req = '0; ch_wr_type = '0; ch_wr_addr = '0;
    ch_wr_wstrb = '0; ch_wr_data = '0;
    rd_rdy = 1'b0; ret_valid = 1'b0; ret_last = 1'b0; ret_data = '0;
    wr_rdy = 1'b0;
  endtask

  // Leaves the caller at a falling edge with reset released and FSMs idle
  task automatic apply_reset();
    clear_inputs();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    resetn = 1'b0;
    @(negedge clk);
    vectors++; if (rd_req !== 1'b0 || wr_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: rd_req=%b wr_req=%b expected 0 0", rd_req, wr_req); end
    vectors++; if (ch_ret_valid !== 4'b0000 || ch_ret_last !== 4'b0000) begin miscompares++; $display("FAIL reset_ret: valid=%b last=%b expected 0000 0000", ch_ret_valid, ch_ret_last); end
    vectors++; if (rd_addr !== 32'h0 || wr_addr !== 32'h0 || wr_data !== '0 || wr_wstrb !== 4'h0) begin miscompares++; $display("FAIL reset_capture: rd_addr=%h wr_addr=%h wstrb=%h expected all zero", rd_addr, wr_addr, wr_wstrb); end
    resetn = 1'b1;
    @(negedge clk);
    vectors++; if (ch_rd_rdy !== 4'b0000 || ch_wr_rdy !== 4'b0000) begin miscompares++; $display("FAIL idle_rdy: rd_rdy=%b wr_rdy=%b expected 0000 0000", ch_rd_rdy, ch_wr_rdy); end
  endtask

  task automatic test_single_read();
    logic [3:0] exp_last;
    apply_reset();
    ch_rd_req = 4'b0010;
    ch_rd_type[3 +: 3] = SZ_LINE;
    ch_rd_addr[32 +: 32] = 32'h1FC0_0100;
    #1;
    vectors++; if (ch_rd_rdy !== 4'b0010) begin miscompares++; $display("FAIL single_rdy: got %b expected 0010", ch_rd_rdy); end
    vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL single_req_c0: got %b expected 0", rd_req); end
    @(negedge clk);
    ch_rd_req = '0;
    #1;
    vectors++; if (rd_req !== 1'b1 || rd_addr !== 32'h1FC0_0100 || rd_type !== SZ_LINE) begin miscompares++; $display("FAIL single_bridge_req: req=%b addr=%h type=%b expected 1 1fc00100 100", rd_req, rd_addr, rd_type); end
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    #1;
    vectors++; if (rd_req !== 1'b0) begin miscompares++; $display("FAIL single_resp_req: got %b expected 0", rd_req); end
    for (int b = 0; b < 4; b++) begin
      ret_valid = 1'b1;
      ret_last  = (b == 3);
      ret_data  = 32'hA000_0000 + b;
      exp_last  = (b == 3) ? 4'b0010 : 4'b0000;
      #1;
      vectors++; if (ch_ret_valid !== 4'b0010 || ch_ret_last !== exp_last || ch_ret_data !== 32'hA000_0000 + b) begin miscompares++; $display("FAIL single_beat%0d: valid=%b last=%b data=%h expected 0010 %b %h", b, ch_ret_valid, ch_ret_last, ch_ret_data, exp_last, 32'hA000_0000 + b); end
      @(negedge clk);
    end
    ret_valid = 1'b0;
    ret_last  = 1'b0;
    ch_rd_req = 4'b0001;
    #1;
    vectors++; if (ch_rd_rdy !== 4'b0001) begin miscompares++; $display("FAIL single_turnaround: got %b expected 0001", ch_rd_rdy); end
    ch_rd_req = '0;
  endtask

  task automatic test_contention();
    logic [3:0]  exp_gnt [4];
    logic [31:0] exp_addr [4];
`ifdef ARB_RR_EN
    exp_gnt  = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    exp_addr = '{32'h0000_0100, 32'h0000_0200, 32'h0000_0100, 32'h0000_0200};
`else
    exp_gnt  = '{4'b0001, 4'b0001, 4'b0001, 4'b0001};
    exp_addr = '{32'h0000_0100, 32'h0000_0100, 32'h0000_0100, 32'h0000_0100};
`endif
    apply_reset();
    ch_rd_req = 4'b0101;
    ch_rd_type[0 +: 3] = SZ_WORD;
    ch_rd_type[6 +: 3] = SZ_WORD;
    ch_rd_addr[0 +: 32]  = 32'h0000_0100;
    ch_rd_addr[64 +: 32] = 32'h0000_0200;
    for (int i = 0; i < 4; i++) begin
      #1;
      vectors++; if (ch_rd_rdy !== exp_gnt[i]) begin miscompares++; $display("FAIL contention_gnt%0d: got %b expected %b", i, ch_rd_rdy, exp_gnt[i]); end
      @(negedge clk);
      #1;
      vectors++; if (rd_addr !== exp_addr[i]) begin miscompares++; $display("FAIL contention_addr%0d: got %h expected %h", i, rd_addr, exp_addr[i]); end
      rd_rdy = 1'b1;
      @(negedge clk);
      rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1;
      @(negedge clk);
      ret_valid = 1'b0; ret_last = 1'b0;
    end
    ch_rd_req = 4'b0100;
    #1;
    vectors++; if (ch_rd_rdy !== 4'b0100) begin miscompares++; $display("FAIL contention_ch2_after_drop: got %b expected 0100", ch_rd_rdy); end
    ch_rd_req = '0;
  endtask

  task automatic test_hazard();
    apply_reset();
    ch_wr_req = 4'b0010;
    ch_wr_type[3 +: 3] = SZ_LINE;
    ch_wr_addr[32 +: 32] = 32'h0000_1040;
    ch_wr_wstrb[4 +: 4] = 4'hF;
    ch_wr_data[LINE_W +: LINE_W] = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    #1;
    vectors++; if (ch_wr_rdy !== 4'b0010) begin miscompares++; $display("FAIL hazard_wr_rdy: got %b expected 0010", ch_wr_rdy); end
    @(negedge clk);
    ch_wr_req = '0;
    ch_rd_req = 4'b0011;
    ch_rd_type[0 +: 3] = SZ_WORD;
    ch_rd_type[3 +: 3] = SZ_WORD;
    ch_rd_addr[0 +: 32]  = 32'h0000_2000;
    ch_rd_addr[32 +: 32] = 32'h0000_1048;
    #1;
    vectors++; if (wr_req !== 1'b1 || wr_addr !== 32'h0000_1040) begin miscompares++; $display("FAIL hazard_wr_held: req=%b addr=%h expected 1 00001040", wr_req, wr_addr); end
    vectors++; if (ch_rd_rdy !== 4'b0001) begin miscompares++; $display("FAIL hazard_other_granted: got %b expected 0001", ch_rd_rdy); end
    @(negedge clk);
    ch_rd_req = 4'b0010;
    #1;
    vectors++; if (rd_req !== 1'b1 || rd_addr !== 32'h0000_2000) begin miscompares++; $display("FAIL hazard_ch0_bridge: req=%b addr=%h expected 1 00002000", rd_req, rd_addr); end
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0; ret_valid = 1'b1; ret_last = 1'b1;
    #1;
    vectors++; if (ch_ret_valid !== 4'b0001) begin miscompares++; $display("FAIL hazard_ch0_ret: got %b expected 0001", ch_ret_valid); end
    @(negedge clk);
    ret_valid = 1'b0; ret_last = 1'b0;
    #1;
    vectors++; if (ch_rd_rdy !== 4'b0000) begin miscompares++; $display("FAIL hazard_blocked1: got %b expected 0000", ch_rd_rdy); end
    @(negedge clk);
    #1;
    vectors++; if (ch_rd_rdy !== 4'b0000 || wr_req !== 1'b1) begin miscompares++; $display("FAIL hazard_blocked2: rdy=%b wr_req=%b expected 0000 1", ch_rd_rdy, wr_req); end
    wr_rdy = 1'b1;
    @(negedge clk);
    wr_rdy = 1'b0;
    #1;
    vectors++; if (ch_rd_rdy !== 4'b0010 || wr_req !== 1'b0) begin miscompares++; $display("FAIL hazard_release: rdy=%b wr_req=%b expected 0010 0", ch_rd_rdy, wr_req); end
    @(negedge clk);
    ch_rd_req = '0;
    #1;
    vectors++; if (rd_req !== 1'b1 || rd_addr !== 32'h0000_1048) begin miscompares++; $display("FAIL hazard_ch1_bridge: req=%b addr=%h expected 1 00001048", rd_req, rd_addr); end
  endtask

  task automatic test_concurrency();
    apply_reset();
    ch_wr_req = 4'b1000;
    ch_wr_type[9 +: 3] = SZ_WORD;
    ch_wr_addr[96 +: 32] = 32'h0000_3000;
    ch_wr_wstrb[12 +: 4] = 4'b0011;
    ch_wr_data[3*LINE_W +: LINE_W] = 128'h0000_0000_0000_0000_0000_0000_0000_BEEF;
    // Same line as the write: the write is not captured yet, so no hazard
    ch_rd_req = 4'b0100;
    ch_rd_type[6 +: 3] = SZ_WORD;
    ch_rd_addr[64 +: 32] = 32'h0000_3004;
    #1;
    vectors++; if (ch_wr_rdy !== 4'b1000 || ch_rd_rdy !== 4'b0100) begin miscompares++; $display("FAIL conc_rdy: wr=%b rd=%b expected 1000 0100", ch_wr_rdy, ch_rd_rdy); end
    vectors++; if (rd_req !== 1'b0 || wr_req !== 1'b0) begin miscompares++; $display("FAIL conc_req_c0: rd=%b wr=%b expected 0 0", rd_req, wr_req); end
    @(negedge clk);
    ch_wr_req = '0;
    ch_rd_req = '0;
    #1;
    vectors++; if (rd_req !== 1'b1 || wr_req !== 1'b1) begin miscompares++; $display("FAIL conc_req_c1: rd=%b wr=%b expected 1 1", rd_req, wr_req); end
    vectors++; if (rd_addr !== 32'h0000_3004 || rd_type !== SZ_WORD) begin miscompares++; $display("FAIL conc_rd_fields: addr=%h type=%b expected 00003004 010", rd_addr, rd_type); end
    vectors++; if (wr_addr !== 32'h0000_3000 || wr_type !== SZ_WORD || wr_wstrb !== 4'b0011 || wr_data !== 128'h0000_0000_0000_0000_0000_0000_0000_BEEF) begin miscompares++; $display("FAIL conc_wr_fields: addr=%h type=%b wstrb=%b data=%h expected 00003000 010 0011 beef", wr_addr, wr_type, wr_wstrb, wr_data); end
  endtask

  task automatic test_stray_beat();
    apply_reset();
    ret_valid = 1'b1; ret_last = 1'b1; ret_data = 32'hDEAD_BEEF;
    #1;
    vectors++; if (ch_ret_valid !== 4'b0000 || ch_ret_last !== 4'b0000) begin miscompares++; $display("FAIL stray_idle: valid=%b last=%b expected 0000 0000", ch_ret_valid, ch_ret_last); end
    @(negedge clk);
    ret_valid = 1'b0; ret_last = 1'b0;
    ch_rd_req = 4'b1000;
    ch_rd_addr[96 +: 32] = 32'h0000_5000;
    @(negedge clk);
    ch_rd_req = '0;
    ret_valid = 1'b1; ret_last = 1'b1;
    #1;
    vectors++; if (ch_ret_valid !== 4'b0000 || rd_req !== 1'b1) begin miscompares++; $display("FAIL stray_req_state: valid=%b rd_req=%b expected 0000 1", ch_ret_valid, rd_req); end
    @(negedge clk);
    ret_valid = 1'b0; ret_last = 1'b0;
    #1;
    vectors++; if (rd_req !== 1'b1) begin miscompares++; $display("FAIL stray_stays_req: rd_req=%b expected 1", rd_req); end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ch_rd_req = 4'b0010;
    ch_rd_type[3 +: 3] = SZ_LINE;
    ch_rd_addr[32 +: 32] = 32'h1FC0_0200;
    @(negedge clk);
    ch_rd_req = '0;
    rd_rdy = 1'b1;
    @(negedge clk);
    rd_rdy = 1'b0;
    ret_valid = 1'b1; ret_last = 1'b0;
    #1;
    vectors++; if (ch_ret_valid !== 4'b0010) begin miscompares++; $display("FAIL rstmid_beat1: got %b expected 0010", ch_ret_valid); end
    @(negedge clk);
    #1;
    vectors++; if (ch_ret_valid !== 4'b0010) begin miscompares++; $display("FAIL rstmid_beat2: got %b expected 0010", ch_ret_valid); end
    resetn = 1'b0;
    #1;
    vectors++; if (ch_ret_valid !== 4'b0000 || rd_req !== 1'b0 || wr_req !== 1'b0 || rd_addr !== 32'h0) begin miscompares++; $display("FAIL rstmid_async: valid=%b rd_req=%b wr_req=%b rd_addr=%h expected 0000 0 0 0", ch_ret_valid, rd_req, wr_req, rd_addr); end
    @(negedge clk);
    resetn = 1'b1;
    #1;
    vectors++; if (ch_ret_valid !== 4'b0000) begin miscompares++; $display("FAIL rstmid_beat3: got %b expected 0000", ch_ret_valid); end
    @(negedge clk);
    ret_last = 1'b1;
    #1;
    vectors++; if (ch_ret_valid !== 4'b0000 || ch_ret_last !== 4'b0000) begin miscompares++; $display("FAIL rstmid_beat4: valid=%b last=%b expected 0000 0000", ch_ret_valid, ch_ret_last); end
    @(negedge clk);
    ret_valid = 1'b0; ret_last = 1'b0;
    ch_rd_req = 4'b0001;
    #1;
    vectors++; if (ch_rd_rdy !== 4'b0001 || rd_req !== 1'b0) begin miscompares++; $display("FAIL rstmid_idle: rdy=%b rd_req=%b expected 0001 0", ch_rd_rdy, rd_req); end
    ch_rd_req = '0;
  endtask

  initial begin
    resetn = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_hazard();
    test_concurrency();
    test_stray_beat();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_req_arbiter.md
# mem_req_arbiter

Parametrised memory-request arbiter between the core's cache/uncache agents (icache, dcache, instruction uncache, data uncache) and the single cache-to-AXI bridge port. It takes over from the fixed two-way cache/uncache select muxes and adds N-channel arbitration, registered request capture, response routing and a read-after-write line hazard check. Reads and writes are arbitrated independently. One read and one write may be in flight at a time.

## Interface
Parameters:
- NCH, 4: number of requesting channels; ch0 icache, ch1 dcache, ch2 I-uncache, ch3 D-uncache.
- LINE_W, 128: write-data width in bits; must be a power of two ≥32.
- OFF_W, $clog2(LINE_W/8): line-offset bits ignored by the hazard compare.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- resetn  in  1  asynchronous, active-low reset.
- ch_rd_req  in  NCH  per-channel read request.
- ch_rd_type  in  3*NCH  000 byte, 001 half, 010 word, 100 line.
- ch_rd_addr  in  32*NCH  physical read address.
- ch_rd_rdy  out  NCH  read accepted (one-hot, combinational).
- ch_ret_valid  out  NCH  return beat for the granted channel.
- ch_ret_last  out  NCH  last return beat.
- ch_ret_data  out  32  return data, broadcast to all channels.
- ch_wr_req  in  NCH  per-channel write request.
- ch_wr_type  in  3*NCH  same encoding as read.
- ch_wr_addr  in  32*NCH  physical write address.
- ch_wr_wstrb  in  4*NCH  byte strobes.
- ch_wr_data  in  LINE_W*NCH  write data.
- ch_wr_rdy  out  NCH  write accepted (one-hot, combinational).
- rd_req, rd_type[2:0], rd_addr[31:0]  out  bridge read request.
- rd_rdy  in  1  bridge accepts read.
- ret_valid, ret_last  in  1  bridge return beat.
- ret_data  in  32  bridge return data.
- wr_req, wr_type[2:0], wr_addr[31:0], wr_wstrb[3:0], wr_data[LINE_W-1:0]  out  bridge write request.
- wr_rdy  in  1  bridge accepts write.

## Operation
- Read FSM has three states: R_IDLE, R_REQ and R_RESP.
- In R_IDLE, the winner among eligible ch_rd_req gets ch_rd_rdy. On that edge its type and address are captured into registers, the grant index is stored, and the FSM moves to R_REQ.
- In R_REQ, rd_req=1 and the registered fields drive the bridge. When rd_rdy=1 at the edge, the FSM moves to R_RESP.
- In R_RESP, ch_ret_valid[g]=ret_valid and ch_ret_last[g]=ret_last; all other channels see 0. When ret_valid and ret_last are both 1 at the edge, the FSM returns to R_IDLE.
- ret_valid in R_IDLE or R_REQ is ignored.
- Write FSM has two states: W_IDLE and W_REQ.
- In W_IDLE, the winner gets ch_wr_rdy and its fields are captured; the FSM moves to W_REQ.
- In W_REQ, wr_req=1 until wr_rdy; the FSM then returns to W_IDLE.
- Hazard check: a read channel is ineligible while the write FSM is in W_REQ and rd_addr[31:OFF_W] equals the captured wr_addr[31:OFF_W]. Ineligible channels do not block other eligible channels.
- The read and write paths are independent. Simultaneous read and write grants in the same cycle are allowed. A read and a write issued in the same cycle do not hazard against each other; the write is not yet captured.
- A channel keeps its request asserted until it sees rdy. The arbiter never drops an accepted request.

## Timing
- Reset values: FSMs in R_IDLE/W_IDLE. rd_req=0, wr_req=0, all ch_*_rdy/valid/last=0. Captured fields 0. Round-robin pointers 0.
- Latency: a request in cycle 0 gives ch_*_rdy in cycle 0 and bridge rd_req/wr_req at cycle 1.
- Minimum read turnaround: a new grant is possible in the cycle after the last beat.
- rdy outputs depend combinationally on ch_*_req and state only, never on bridge inputs.
- Reset mid-transaction abandons the transfer immediately. No response is routed after reset release.

## Configuration
- ARB_RR_EN defined: round-robin arbitration per path.
  - Search starts at ptr.
  - After a grant to g, ptr becomes (g+1) mod NCH.
- ARB_RR_EN undefined: fixed priority, lowest eligible index wins. Pointers are not implemented.

## Structure
- Shared package mem_arb_pkg holds:
  - type encodings (SZ_BYTE, SZ_HALF, SZ_WORD, SZ_LINE)
  - read state enum {R_IDLE, R_REQ, R_RESP}
  - write state enum {W_IDLE, W_REQ}
- One sub-module, arb_pick: combinational one-hot winner from req[NCH] and ptr, with ARB_RR_EN handled inside. It is instantiated twice, once for read and once for write.

## Test plan
- Single read: ch1 reads line 0x1FC0_0100 → ch_rd_rdy=0010 in cycle 0, rd_req at cycle 1, 4 beats routed only to ch_ret_valid[1], ret_last on beat 4, then R_IDLE.
- Contention (RR build): ch0 and ch2 both request continuously → grants alternate 0, 2, 0, 2. Fixed build: always 0 until ch0 drops.
- Hazard: ch1 write to 0x0000_1040 held in W_REQ (wr_rdy=0); ch1 read 0x0000_1048 blocked while ch0 read 0x0000_2000 is granted; the ch1 read is granted the cycle after wr_rdy.
- Concurrency: same-cycle ch3 word write with wstrb 0011 and ch2 word read → both rdy in cycle 0, both bridge requests at cycle 1.
- Stray beat: ret_valid=1 in R_IDLE → all ch_ret_valid stay 0.
- Reset: resetn low during R_RESP beat 2 → all outputs 0 asynchronously; after release, remaining beats are ignored.
